// File: rtl/floor_call_scheduler_if.sv
// Bus between the call buttons, the floor mover and floor_call_scheduler.
// door_hold is present only when DOOR_HOLD_EN is defined.
interface floor_call_scheduler_if #(
   parameter int N_FLOORS = 4
);
   // No valid/ready handshake: call_req and cur_floor are levels sampled on every clk,
   // tick is a one-clk strobe, and every output is a registered level.
   logic                tick;
   logic [N_FLOORS-1:0] call_req;
   logic [N_FLOORS-1:0] cur_floor;
   logic [N_FLOORS-1:0] target_floor;
   logic                door_open;
   logic                moving;
   logic                dir_up;
   logic [N_FLOORS-1:0] pending;
   logic [1:0]          state_dbg;
`ifdef DOOR_HOLD_EN
   logic                door_hold;
`endif

   modport master (
      output tick, call_req, cur_floor,
`ifdef DOOR_HOLD_EN
      output door_hold,
`endif
      input  target_floor, door_open, moving, dir_up, pending, state_dbg
   );

   modport slave (
      input  tick, call_req, cur_floor,
`ifdef DOOR_HOLD_EN
      input  door_hold,
`endif
      output target_floor, door_open, moving, dir_up, pending, state_dbg
   );
endinterface

// File: rtl/floor_call_scheduler.sv
// SCAN floor-call scheduler: latches calls, picks the next target floor and runs the door dwell.
// Optional DOOR_HOLD_EN adds door_hold, which freezes the dwell counter at 0 while asserted.
module floor_call_scheduler #(
   parameter int N_FLOORS   = 4,
   parameter int DOOR_TICKS = 3
) (
   input logic                    clk,
   input logic                    reset,
   floor_call_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DOOR = 2'd2
   } state_t;

   localparam logic [N_FLOORS-1:0] LP_FLOOR0 = {{(N_FLOORS-1){1'b0}}, 1'b1};
   localparam logic [3:0]          LP_LAST   = 4'(DOOR_TICKS - 1);

   state_t              r_state;
   logic [N_FLOORS-1:0] r_pending;
   logic [N_FLOORS-1:0] r_target;
   logic                r_dir_up;
   logic [3:0]          r_cnt;

   state_t              w_state_nxt;
   logic [N_FLOORS-1:0] w_target_nxt;
   logic                w_dir_nxt;
   logic [3:0]          w_cnt_nxt;
   logic [N_FLOORS-1:0] w_clear;
   logic                w_cur_valid;
   logic [N_FLOORS-1:0] w_near_up;
   logic [N_FLOORS-1:0] w_near_dn;
   logic [N_FLOORS-1:0] w_sel;
   logic                w_sel_dir;
   logic                w_hold;

   // Nearest pending floor strictly above the one-hot floor cur.
   function automatic logic [N_FLOORS-1:0] f_near_up(input logic [N_FLOORS-1:0] pend,
                                                      input logic [N_FLOORS-1:0] cur);
      logic                seen;
      logic [N_FLOORS-1:0] res;
      seen = 1'b0;
      res  = '0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (seen && pend[i] && (res == '0)) res[i] = 1'b1;
         if (cur[i]) seen = 1'b1;
      end
      return res;
   endfunction

   // Nearest pending floor strictly below the one-hot floor cur.
   function automatic logic [N_FLOORS-1:0] f_near_dn(input logic [N_FLOORS-1:0] pend,
                                                      input logic [N_FLOORS-1:0] cur);
      logic                seen;
      logic [N_FLOORS-1:0] res;
      seen = 1'b0;
      res  = '0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (seen && pend[i] && (res == '0)) res[i] = 1'b1;
         if (cur[i]) seen = 1'b1;
      end
      return res;
   endfunction

`ifdef DOOR_HOLD_EN
   assign w_hold = bus.door_hold;
`else
   assign w_hold = 1'b0;
`endif

   assign w_cur_valid = $onehot(bus.cur_floor);
   assign w_near_up   = f_near_up(r_pending, bus.cur_floor);
   assign w_near_dn   = f_near_dn(r_pending, bus.cur_floor);

   // Keep the scan direction if it still has work, otherwise flip.
   always_comb begin
      w_sel     = '0;
      w_sel_dir = r_dir_up;
      if (r_dir_up) begin
         if (w_near_up != '0) begin
            w_sel     = w_near_up;
            w_sel_dir = 1'b1;
         end else begin
            w_sel     = w_near_dn;
            w_sel_dir = 1'b0;
         end
      end else begin
         if (w_near_dn != '0) begin
            w_sel     = w_near_dn;
            w_sel_dir = 1'b0;
         end else begin
            w_sel     = w_near_up;
            w_sel_dir = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_target_nxt = r_target;
      w_dir_nxt    = r_dir_up;
      w_cnt_nxt    = r_cnt;
      if (w_cur_valid) begin
         case (r_state)
            S_IDLE: begin
               if ((r_pending & bus.cur_floor) != '0) begin
                  w_state_nxt  = S_DOOR;
                  w_target_nxt = bus.cur_floor;
                  w_cnt_nxt    = 4'd0;
               end else if (r_pending != '0) begin
                  w_state_nxt  = S_MOVE;
                  w_target_nxt = w_sel;
                  w_dir_nxt    = w_sel_dir;
               end else begin
                  w_target_nxt = bus.cur_floor;
               end
            end
            S_MOVE: begin
               // En-route pickup only ever pulls the target closer; MOVE never reverses.
               if (bus.cur_floor == r_target) begin
                  w_state_nxt = S_DOOR;
                  w_cnt_nxt   = 4'd0;
               end else if (r_dir_up) begin
                  if ((w_near_up != '0) && (w_near_up < r_target)) w_target_nxt = w_near_up;
               end else begin
                  if (w_near_dn > r_target) w_target_nxt = w_near_dn;
               end
            end
            S_DOOR: begin
               if ((bus.call_req & bus.cur_floor) != '0) begin
                  w_cnt_nxt = 4'd0;
               end else if (w_hold) begin
                  w_cnt_nxt = 4'd0;
               end else if (bus.tick) begin
                  if (r_cnt == LP_LAST) begin
                     w_cnt_nxt = 4'd0;
                     if (w_sel != '0) begin
                        w_state_nxt  = S_MOVE;
                        w_target_nxt = w_sel;
                        w_dir_nxt    = w_sel_dir;
                     end else begin
                        w_state_nxt  = S_IDLE;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + 4'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Clearing beats a simultaneous new call on the same floor.
   assign w_clear = (w_cur_valid && ((r_state == S_DOOR) || (w_state_nxt == S_DOOR)))
                    ? bus.cur_floor : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_target  <= LP_FLOOR0;
         r_dir_up  <= 1'b1;
         r_cnt     <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= (r_pending | bus.call_req) & ~w_clear;
         r_target  <= w_target_nxt;
         r_dir_up  <= w_dir_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   assign bus.target_floor = r_target;
   assign bus.door_open    = (r_state == S_DOOR);
   assign bus.moving       = (r_state == S_MOVE);
   assign bus.dir_up       = r_dir_up;
   assign bus.pending      = r_pending;
   assign bus.state_dbg    = r_state;

endmodule

// File: doc/floor_call_scheduler.md
Name: floor_call_scheduler

Overview:
- Collects floor call requests from up to four floors, holds them as pending calls, and selects the next target floor with SCAN ordering (keep going in the current direction while calls remain that way).
- Drives the one-hot target floor consumed by the one-floor-per-tick floor mover, watches the mover's one-hot present floor, and runs the door dwell.
- Sits between the call buttons (ui_in) and the floor mover FSM; shares the single car among all requesters.

Parameters:
- N_FLOORS, 4, number of floors; one-hot vector width. Only 4 is supported.
- DOOR_TICKS, 3, door dwell length in one-second ticks (1..15).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle one-second strobe, shared with the floor mover
- call_req  input  N_FLOORS  level call inputs, bit i = floor i; sampled every clk
- cur_floor  input  N_FLOORS  one-hot present floor from the mover
- target_floor  output  N_FLOORS  one-hot requested floor to the mover
- door_open  output  1  high while the car dwells at a floor
- moving  output  1  high in MOVE state
- dir_up  output  1  current scan direction (1 = up)
- pending  output  N_FLOORS  outstanding calls

Behaviour:
- Reset (async): state=IDLE, pending=0, target_floor=4'b0001, door_open=0, moving=0, dir_up=1, dwell counter=0.
- Every clk: pending <= (pending | call_req) & ~clear_mask. clear_mask is cur_floor when the block is entering or sitting in DOOR, else 0. If a clear and a set hit the same bit in the same cycle, the clear wins.
- Selection (combinational, from pending and cur_floor):
  - above = pending bits strictly higher than cur_floor; below = pending bits strictly lower.
  - If dir_up: nearest bit of above, else nearest bit of below (flip dir).
  - If not dir_up: nearest bit of below, else nearest bit of above (flip dir).
  - The direction flip is registered when the selection is taken.
- Non-one-hot cur_floor: treated as no floor. No arrival, no clear, no selection; the block holds its state.
- States:
  - IDLE: target_floor=cur_floor, moving=0.
    - Pending call at cur_floor -> DOOR next cycle.
    - Else any pending -> register the selection into target_floor and dir_up, go to MOVE.
    - Else stay in IDLE.
  - MOVE: moving=1. Each cycle, recompute the nearest pending call in the current direction and update target_floor if it is nearer. This picks up calls en route; the block never reverses while in MOVE.
    - cur_floor==target_floor -> DOOR; clear that pending bit; dwell counter=0.
  - DOOR: door_open=1, target_floor=cur_floor. The counter increments on each tick.
    - A new call at cur_floor is absorbed (cleared) and resets the counter to 0.
    - Counter reaches DOOR_TICKS -> door_open=0. Go to MOVE via the selection if any call is pending, else to IDLE.
- Outputs are registered and change one clk after the causing event. Arrival to door_open=1 takes 1 clk.
- Reset mid-MOVE or mid-DOOR: all outputs return to reset values immediately; pending calls are lost.
- target_floor is always one-hot, and never changes while door_open=1.

Optional Feature:
- Macro DOOR_HOLD_EN.
- Defined: adds input port door_hold (1 bit). While door_hold=1 in DOOR, the dwell counter is held at 0 and ticks are ignored; dwell resumes on release.
- Not defined: no door_hold port; dwell is always exactly DOOR_TICKS ticks after the last absorbed call.

Test Plan:
- Reset, idle at floor 0, call_req=4'b1000 for 1 clk -> pending=1000, next clk target_floor=1000, dir_up=1, moving=1; mover reaching cur_floor=1000 -> door_open=1, pending=0000, door closes after 3 ticks, then IDLE.
- At floor 0 in MOVE to floor 3, assert call_req=0100 while cur_floor=0010 -> target_floor becomes 0100; stop at floor 2 with door open, then resume to 1000.
- At floor 2 going up with pending=1001 -> serve floor 3 first, then dir_up=0, target_floor=0001.
- In DOOR at floor 1, pulse call_req=0010 after 2 ticks -> pending bit stays 0, dwell restarts, door_open stays high for 3 more ticks.
- Assert reset while moving with pending=1010 -> async reset: target_floor=0001, pending=0000, door_open=0, moving=0, dir_up=1.
- With DOOR_HOLD_EN defined, hold door_hold=1 for 10 ticks in DOOR -> door_open stays 1; after release, closes after exactly 3 ticks.
